// File: rtl/uart_rx_frame_ctrl.sv
// UART byte-stream framer: SOF, LEN, payload, XOR checksum; payload is released on a valid/ready stream once the checksum verifies.
// Optional build macro UART_FRM_STATS_EN adds saturating good/error frame counters.
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 870
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Valid,
  output logic [7:0]  o_Data,
  output logic        o_Last,
  input  logic        i_Ready,
  output logic        o_Frame_Ok,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Overrun,
  output logic [2:0]  o_Dbg_State
`ifdef UART_FRM_STATS_EN
  ,
  output logic [15:0] o_Good_Cnt,
  output logic [15:0] o_Err_Cnt
`endif
);
  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CLKS);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] ERR_CHK = 2'b01, ERR_LEN = 2'b10, ERR_TO = 2'b11;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_e;

  // Stream handshake: a beat transfers on a cycle where o_Valid and i_Ready are both high;
  // while o_Valid is high and i_Ready low, o_Data and o_Last hold.
  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d, acc_q, acc_d, data_q, data_d, len_m1;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_idx_q, rd_idx_d, rd_next;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic              frame_ok_q, frame_ok_d, err_q, err_d, overrun_q, overrun_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        buf_q [MAX_LEN];
  logic              buf_we;
  logic [BUF_AW-1:0] buf_wa;

  assign len_m1  = len_q - 8'd1;
  assign rd_next = rd_idx_q + IDX_W'(1);
  assign buf_wa  = idx_q[BUF_AW-1:0];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rd_idx_d   = rd_idx_q;
    acc_d      = acc_q;
    to_cnt_d   = to_cnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    frame_ok_d = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    overrun_d  = 1'b0;
    buf_we     = 1'b0;
    case (state_q)
      S_HUNT: begin
        to_cnt_d = '0;
        if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) state_d = S_LEN;
      end
      S_LEN, S_PAYLOAD, S_CHK: begin
        if (i_Rx_DV) begin
          // A byte landing on the expiry cycle still counts as activity.
          to_cnt_d = '0;
          case (state_q)
            S_LEN: begin
              if (i_Rx_Byte > MAX_LEN_B) begin
                err_d      = 1'b1;
                err_code_d = ERR_LEN;
                state_d    = S_HUNT;
              end else begin
                len_d   = i_Rx_Byte;
                idx_d   = '0;
                acc_d   = i_Rx_Byte;
                state_d = (i_Rx_Byte == 8'd0) ? S_CHK : S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              buf_we = 1'b1;
              acc_d  = acc_q ^ i_Rx_Byte;
              idx_d  = idx_q + IDX_W'(1);
              if (8'(idx_q) == len_m1) state_d = S_CHK;
            end
            S_CHK: begin
              if (i_Rx_Byte == acc_q) begin
                frame_ok_d = 1'b1;
                if (len_q != 8'd0) begin
                  state_d  = S_DRAIN;
                  valid_d  = 1'b1;
                  rd_idx_d = '0;
                  data_d   = buf_q[{BUF_AW{1'b0}}];
                  last_d   = (len_q == 8'd1);
                end else begin
                  state_d = S_HUNT;
                end
              end else begin
                err_d      = 1'b1;
                err_code_d = ERR_CHK;
                state_d    = S_HUNT;
              end
            end
            default: ;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d   = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TO;
          state_d    = S_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DRAIN: begin
        to_cnt_d = '0;
        if (i_Rx_DV) overrun_d = 1'b1;
        if (valid_q && i_Ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_HUNT;
          end else begin
            rd_idx_d = rd_next;
            data_d   = buf_q[rd_next[BUF_AW-1:0]];
            last_d   = (8'(rd_next) == len_m1);
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_HUNT;
      len_q      <= '0;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      acc_q      <= '0;
      to_cnt_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      acc_q      <= acc_d;
      to_cnt_q   <= to_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      frame_ok_q <= frame_ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      overrun_q  <= overrun_d;
    end
  end

  // Payload storage carries no reset; contents only matter after being written.
  always_ff @(posedge i_Clock) begin
    if (buf_we) buf_q[buf_wa] <= i_Rx_Byte;
  end

  assign o_Valid     = valid_q;
  assign o_Data      = data_q;
  assign o_Last      = last_q;
  assign o_Frame_Ok  = frame_ok_q;
  assign o_Err       = err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Overrun   = overrun_q;
  assign o_Dbg_State = state_q;

`ifdef UART_FRM_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (frame_ok_q && good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
    if (err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_Good_Cnt = good_cnt_q;
  assign o_Err_Cnt  = err_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: payload beats are scored against an expected queue,
// pulses and error codes are checked at the cycle they must appear.
module tb_uart_rx_frame_ctrl;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         TO      = 870;
  localparam logic [2:0] ST_HUNT = 3'd0, ST_PAYLOAD = 3'd2, ST_CHK = 3'd3, ST_DRAIN = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic [7:0] rx;
  logic       ready;
  logic       o_valid, o_last, o_frame_ok, o_err, o_overrun;
  logic [7:0] o_data;
  logic [1:0] o_err_code;
  logic [2:0] o_state;
`ifdef UART_FRM_STATS_EN
  logic [15:0] o_good_cnt, o_err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int cyc;
  logic [8:0] exp_q[$];
  logic [8:0] exp_beat;

  uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rx),
    .o_Valid(o_valid), .o_Data(o_data), .o_Last(o_last), .i_Ready(ready),
    .o_Frame_Ok(o_frame_ok), .o_Err(o_err), .o_Err_Code(o_err_code),
    .o_Overrun(o_overrun), .o_Dbg_State(o_state)
`ifdef UART_FRM_STATS_EN
    , .o_Good_Cnt(o_good_cnt), .o_Err_Cnt(o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte per call; returns just after the edge that sampled it.
  task automatic send(input logic [7:0] b);
    dv = 1'b1;
    rx = b;
    @(posedge clk); #1;
    dv = 1'b0;
    rx = 8'h00;
  endtask

  task automatic wait_hunt(input int budget, output int n);
    n = 0;
    while (!(o_state == ST_HUNT && !o_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Scoreboard side: every accepted beat must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_valid && ready) begin
        n_tests++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL beat_unexpected: observed %0h expected none", {o_last, o_data});
        end
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          n_tests++;
          assert ({o_last, o_data} === exp_beat) else begin
            n_fail++;
            $error("FAIL beat: observed %0h expected %0h", {o_last, o_data}, exp_beat);
          end
        end
      end
      if (o_frame_ok) ok_cnt++;
      if (o_err) err_cnt++;
      if (o_overrun) ovr_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; dv = 1'b0; rx = 8'h00; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_valid, o_data, o_last, o_frame_ok, o_err, o_err_code, o_overrun}, 0);
    chk("reset_state", o_state, ST_HUNT);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good frame, back-to-back drain
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    chk("t1_frame_ok", o_frame_ok, 1);
    chk("t1_first_beat", {o_valid, o_last, o_data}, {2'b10, 8'h11});
    wait_hunt(20, cyc);
    chk("t1_drain_cycles", cyc, 3);
    chk("t1_err_none", err_cnt, 0);

    // Bad checksum, then a good frame recovers
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    chk("t2_err", {o_err, o_err_code, o_valid, o_state}, {1'b1, 2'b01, 1'b0, ST_HUNT});
    @(posedge clk); #1;
    chk("t2_err_pulse_code_hold", {o_err, o_err_code}, {1'b0, 2'b01});
    exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b1, 8'h20});
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    chk("t2_recover_ok", o_frame_ok, 1);
    wait_hunt(20, cyc);
    chk("t2_drain_cycles", cyc, 2);

    // Length above MAX_LEN, then a single-beat frame
    send(8'hA5); send(8'h11);
    chk("t3_len_err", {o_err, o_err_code, o_state}, {1'b1, 2'b10, ST_HUNT});
    exp_q.push_back({1'b1, 8'h7E});
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("t3_single_beat", {o_frame_ok, o_valid, o_last, o_data}, {3'b111, 8'h7E});
    wait_hunt(20, cyc);
    chk("t3_drain_cycles", cyc, 1);

    // Timeout fires exactly TO cycles after the last byte
    send(8'hA5); send(8'h02); send(8'h10);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("t4_no_err_early", o_err, 0);
    @(posedge clk); #1;
    chk("t4_timeout", {o_err, o_err_code, o_state}, {1'b1, 2'b11, ST_HUNT});
    // A byte on the expiry cycle suppresses the timeout
    send(8'hA5); send(8'h02); send(8'h10);
    repeat (TO - 1) @(posedge clk);
    #1;
    send(8'h20);
    chk("t4_byte_wins", {o_err, o_state}, {1'b0, ST_CHK});
    exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b1, 8'h20});
    send(8'h32);
    chk("t4_late_frame_ok", o_frame_ok, 1);
    wait_hunt(20, cyc);
    chk("t4_drain_cycles", cyc, 2);

    // Backpressure and overrun; checksum covers LEN as well as payload
    ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
    chk("t5_frame_ok", {o_frame_ok, o_valid, o_last, o_data}, {3'b110, 8'hAA});
    repeat (3) @(posedge clk);
    #1;
    chk("t5_hold", {o_valid, o_last, o_data}, {2'b10, 8'hAA});
    send(8'h55);
    chk("t5_overrun", {o_overrun, o_state, o_valid, o_data}, {1'b1, ST_DRAIN, 1'b1, 8'hAA});
    exp_q.push_back({1'b0, 8'hAA}); exp_q.push_back({1'b1, 8'hBB});
    ready = 1'b1;
    wait_hunt(20, cyc);
    chk("t5_drain_cycles", cyc, 2);
    chk("t5_overrun_count", ovr_cnt, 1);

    // Garbage then zero-length frame
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h00); send(8'h00);
    chk("t6_zero_len_ok", {o_frame_ok, o_valid, o_state}, {2'b10, ST_HUNT});
    @(posedge clk); #1;
    chk("t6_no_beats", o_valid, 0);
    // Reset while mid-payload
    send(8'hA5); send(8'h03); send(8'h11);
    chk("t6_pre_reset_state", o_state, ST_PAYLOAD);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {o_valid, o_data, o_last, o_frame_ok, o_err, o_err_code, o_overrun}, 0);
    chk("t6_reset_state", o_state, ST_HUNT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 8'h7E});
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("t6_after_reset_ok", o_frame_ok, 1);
    wait_hunt(20, cyc);

    @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_frame_ok_count", ok_cnt, 7);
    chk("final_err_count", err_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
